mem_arbiter: RTL and testbench

//  Shares one single-port synchronous video/data RAM between the CPU core (read/write) and
//  the VGA scan-out engine (read-only). Sits between Core/vga_display and the RAM primitive.
//  VGA has fixed priority (real-time pixel fetch); a starvation counter guarantees CPU progress.
//  Req/ack handshake per requester; one access in flight at a time.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/arb_starve_counter.sv | 17 +
 rtl/mem_arbiter.sv | 68 ++++++
 tb/tb_mem_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, owner ids and default widths for the RAM arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
  typedef enum logic {OWN_CPU, OWN_VGA} owner_t;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of VGA grants taken while the CPU waited; hit at LIMIT
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic hit
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || clr) cnt <= '0;
    else if (inc && !hit) cnt <= cnt + 1'b1;
  assign hit = cnt == W'(LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM shared by CPU (rd/wr) and VGA (rd, fixed priority, CPU anti-starvation)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_n;
  owner_t owner;
  logic wr, hit, grant, cpu_win;
  assign cpu_win = cpu_req && (!vga_req || hit);
  assign grant = state == IDLE && enable && (cpu_req || vga_req);
  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk  (clk),
    .reset(reset),
    .clr  (grant && cpu_win),
    .inc  (grant && !cpu_win && cpu_req),
    .hit  (hit)
  );
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb
    state_n = state == IDLE    ? (grant ? ACCESS : IDLE) :
              state == ACCESS  ? (wr ? DONE : CAPTURE) :
              state == CAPTURE ? DONE : IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      cpu_ack   <= 1'b0;
      vga_ack   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      vga_rdata <= '0;
      owner     <= OWN_CPU;
      wr        <= 1'b0;
    end else begin
      cpu_ack <= (state == ACCESS && wr) || (state == CAPTURE && owner == OWN_CPU);
      vga_ack <= state == CAPTURE && owner == OWN_VGA;
      mem_we  <= grant && cpu_win && cpu_we;
      if (grant) begin
        mem_addr <= cpu_win ? cpu_addr : vga_addr;
        owner    <= cpu_win ? OWN_CPU : OWN_VGA;
        wr       <= cpu_win && cpu_we;
        if (cpu_win) mem_wdata <= cpu_wdata;
      end
      if (state == CAPTURE && owner == OWN_CPU) cpu_rdata <= mem_rdata;
      if (state == CAPTURE && owner == OWN_VGA) vga_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized transaction-level checking of mem_arbiter
module tb_mem_arbiter;
  localparam int AW = 15, DW = 16, LIMIT = 4;
  logic clk = 1'b0, reset, enable, cpu_req, cpu_we, vga_req;
  logic [AW-1:0] cpu_addr, vga_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, vga_rdata, mem_wdata, mem_rdata;
  logic cpu_ack, vga_ack, mem_we;
  logic bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] ram [int];
  logic [DW-1:0] shadow [int];
  logic [DW-1:0] exp_crd = '0, exp_vrd = '0;
  int passed = 0, failed = 0, total = 0, starve = 0;
  byte got;
  always #5 clk = ~clk;
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_ack(vga_ack), .vga_rdata(vga_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  function automatic logic [DW-1:0] pat(int a);
    return DW'(a * 37) ^ 16'h5A5A;
  endfunction
  function automatic logic [DW-1:0] ram_rd(int a);
    return ram.exists(a) ? ram[a] : pat(a);
  endfunction
  function automatic logic [DW-1:0] exp_rd(int a);
    return shadow.exists(a) ? shadow[a] : pat(a);
  endfunction
  function automatic logic [AW-1:0] ra();
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 15));
    return ($urandom % 4 == 0) ? ~a : a;
  endfunction
  always @(posedge clk) begin
    mem_rdata <= ram_rd(int'(mem_addr));
    if (bd_we) ram[int'(bd_addr)] = bd_data;
    else if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic round(input bit rnd, input bit drop_en, output byte who);
    bit cw, vw, wrt;
    int lat;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    cw  = enable && cpu_req && (!vga_req || starve == LIMIT);
    vw  = enable && vga_req && !cw;
    wrt = cw && cpu_we;
    a   = cw ? cpu_addr : vga_addr;
    wd  = cpu_wdata;
    lat = !(cw || vw) ? 1 : wrt ? 2 : 3;
    if (vw && cpu_req) starve = starve < LIMIT ? starve + 1 : LIMIT;
    if (cw) starve = 0;
    if (cw && !wrt) exp_crd = exp_rd(int'(a));
    if (vw) exp_vrd = exp_rd(int'(a));
    who = "-";
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("cpu_ack", 32'(cpu_ack), 32'(cw && k == lat));
      chk("vga_ack", 32'(vga_ack), 32'(vw && k == lat));
      chk("mem_we", 32'(mem_we), 32'(wrt && k == 1));
      if (k == 1 && (cw || vw)) chk("mem_addr", 32'(mem_addr), 32'(a));
      if (k == 1 && wrt) chk("mem_wdata", 32'(mem_wdata), 32'(wd));
      if (k == lat && (cw || vw)) begin
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
        chk("vga_rdata", 32'(vga_rdata), 32'(exp_vrd));
      end
      if (k == lat) who = cpu_ack ? "C" : vga_ack ? "V" : "-";
      if (k == 1 && drop_en) enable = 1'b0;
      if (rnd) enable = 1'($urandom % 2);
    end
    if (wrt) shadow[int'(a)] = wd;
    if (cw || vw) begin
      if (cw) cpu_req = 1'b0;
      if (vw) vga_req = 1'b0;
      @(negedge clk);
      chk("idle_acks", 32'({cpu_ack, vga_ack, mem_we}), 32'(0));
    end
  endtask
  initial begin
    reset = 1'b1; enable = 1'b0; cpu_req = 1'b0; vga_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; vga_addr = '0; cpu_wdata = '0;
    bd_we = 1'b1; bd_addr = 15'h0010; bd_data = 16'hBEEF; shadow[16] = 16'hBEEF;
    repeat (3) @(negedge clk);
    bd_we = 1'b0;
    chk("rst_acks", 32'({cpu_ack, vga_ack, mem_we}), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_rdata", 32'({cpu_rdata, vga_rdata}), 32'(0));
    reset = 1'b0; enable = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    round(0, 0, got);
    chk("t1_who", 32'(got), 32'("C"));
    chk("t1_rdata", 32'(cpu_rdata), 32'(16'hBEEF));
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h7FFF; cpu_wdata = 16'h1234;
    round(0, 0, got);
    cpu_req = 1'b1; cpu_we = 1'b0;
    round(0, 0, got);
    chk("t2_readback", 32'(cpu_rdata), 32'(16'h1234));
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0020; cpu_wdata = 16'hDEAD;
    vga_req = 1'b1; vga_addr = 15'h0020;
    round(0, 0, got);
    chk("t4_who", 32'(got), 32'("V"));
    chk("t4_ram_kept", 32'(ram_rd(32)), 32'(pat(32)));
    round(0, 0, got);
    chk("t4_cpu_write", 32'(ram_rd(32)), 32'(16'hDEAD));
    for (int i = 0; i < 10; i++) begin
      if (!cpu_req) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom % 2); cpu_addr = ra(); cpu_wdata = DW'($urandom);
      end
      if (!vga_req) begin
        vga_req = 1'b1; vga_addr = ra();
      end
      round(0, 0, got);
      chk("t3_order", 32'(got), 32'(i % 5 == 4 ? "C" : "V"));
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0010;
    vga_req = 1'b1; vga_addr = 15'h0030;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_acks", 32'({cpu_ack, vga_ack, mem_we}), 32'(0));
    chk("t5_mem_addr", 32'(mem_addr), 32'(0));
    chk("t5_rdata", 32'({cpu_rdata, vga_rdata}), 32'(0));
    starve = 0; exp_crd = '0; exp_vrd = '0;
    reset = 1'b0; vga_req = 1'b0;
    round(0, 0, got);
    chk("t5_cpu_after_rst", 32'(got), 32'("C"));
    vga_req = 1'b1; vga_addr = 15'h7FFF;
    round(0, 1, got);
    chk("t6_ack_after_drop", 32'(got), 32'("V"));
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
    vga_req = 1'b1; vga_addr = 15'h0006;
    for (int i = 0; i < 3; i++) begin
      round(0, 0, got);
      chk("t6_no_grant", 32'(got), 32'("-"));
    end
    enable = 1'b1;
    round(0, 0, got);
    chk("t6_regrant", 32'(got), 32'("V"));
    for (int i = 0; i < 300; i++) begin
      if (!cpu_req && $urandom % 2 == 1) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom % 2); cpu_addr = ra(); cpu_wdata = DW'($urandom);
      end
      if (!vga_req && $urandom % 2 == 1) begin
        vga_req = 1'b1; vga_addr = ra();
      end
      enable = $urandom % 8 != 0;
      round(1, 0, got);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
